ysyx_25020037_lsu: RTL

- Load/store unit between EXU and WBU.
- Accepts one executed instruction at a time from EXU. For loads and stores it runs a single AXI4-Lite-style transaction on the data bus.
- Aligns and extends load data, then emits the packed writeback bus consumed by the WBU register/CSR file.
- Non-memory instructions pass through with one-cycle latency.

---
 rtl/ysyx_25020037_lsu.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_25020037_lsu.sv
// Load/store unit sitting between EXU and WBU.
// Takes one executed instruction at a time, runs at most one AXI4-Lite-style
// read or write on the data bus, aligns/extends load data, and presents a
// single-cycle writeback pulse. Non-memory instructions retire one cycle after
// acceptance.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for an instruction from EXU (only state with in_ready)
// AR     | read address phase, m_arvalid held until m_arready
// R      | waiting for read data, m_rready high
// W      | write address and data phases, each valid drops on its handshake
// B      | waiting for write response, m_bready high
// DONE   | one-cycle wb_valid pulse, then back to IDLE
module ysyx_25020037_lsu #(
    parameter int RD_W      = 4,
    parameter int CSR_WEN_W = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [RD_W+CSR_WEN_W+101:0]   in_bus,
    input  logic [31:0]                   in_pc,
    output logic                          wb_valid,
    output logic [RD_W+CSR_WEN_W+64:0]    wb_bus,
    output logic [31:0]                   wb_pc,
    output logic                          wb_err,
    output logic [31:0]                   m_addr,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [31:0]                   m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [31:0]                   m_wdata,
    output logic [3:0]                    m_wstrb,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic [1:0]                    m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready
);

    localparam int WB_W     = RD_W + CSR_WEN_W + 65;
    localparam int CW_LSB   = 96;
    localparam int WE_BIT   = CW_LSB + CSR_WEN_W;
    localparam int RD_LSB   = WE_BIT + 1;
    localparam int F3_LSB   = RD_LSB + RD_W;
    localparam int WEN_BIT  = F3_LSB + 3;
    localparam int REN_BIT  = WEN_BIT + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_W    = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // Decoded fields of the incoming instruction
    logic                 in_ren, in_wen, in_gpr_we;
    logic [2:0]           in_f3;
    logic [RD_W-1:0]      in_rd;
    logic [CSR_WEN_W-1:0] in_csr_wen;
    logic [31:0]          in_csr_wdata, in_result, in_sdata;
    logic                 in_is_mem, in_half, in_word, in_misal;
    logic [3:0]           in_mask;

    assign in_ren       = in_bus[REN_BIT];
    assign in_wen       = in_bus[WEN_BIT];
    assign in_f3        = in_bus[F3_LSB +: 3];
    assign in_rd        = in_bus[RD_LSB +: RD_W];
    assign in_gpr_we    = in_bus[WE_BIT];
    assign in_csr_wen   = in_bus[CW_LSB +: CSR_WEN_W];
    assign in_csr_wdata = in_bus[95:64];
    assign in_result    = in_bus[63:32];
    assign in_sdata     = in_bus[31:0];

    // funct3[1:0]: 00 byte, 01 half, anything else handled as a full word
    assign in_is_mem = in_ren | in_wen;
    assign in_half   = (in_f3[1:0] == 2'b01);
    assign in_word   = in_f3[1];
    assign in_misal  = in_is_mem & ((in_half & in_result[0]) |
                                    (in_word & (in_result[1:0] != 2'b00)));
    assign in_mask   = in_word ? 4'b1111 : (in_half ? 4'b0011 : 4'b0001);

    // Registered state
    logic [2:0]           state_q, state_d;
    logic [2:0]           f3_q, f3_d;
    logic [31:0]          addr_q, addr_d;
    logic                 gpr_we_q, gpr_we_d;
    logic [RD_W-1:0]      rd_q, rd_d;
    logic [CSR_WEN_W-1:0] csr_wen_q, csr_wen_d;
    logic [31:0]          csr_wdata_q, csr_wdata_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic                 aw_pend_q, aw_pend_d;
    logic                 w_pend_q, w_pend_d;
    logic [WB_W-1:0]      wb_bus_q, wb_bus_d;
    logic [31:0]          wb_pc_q, wb_pc_d;
    logic                 wb_err_q, wb_err_d;

    function automatic logic [WB_W-1:0] pack_wb(
        input logic [RD_W-1:0]      rd,
        input logic [CSR_WEN_W-1:0] cw,
        input logic                 we,
        input logic [31:0]          cd,
        input logic [31:0]          gd
    );
        return {rd, cw, we, cd, gd};
    endfunction

    function automatic logic [31:0] load_extract(
        input logic [2:0]  f3,
        input logic [1:0]  lo,
        input logic [31:0] rdata
    );
        logic [31:0] sh;
        logic        sgn;
        sh  = rdata >> {lo, 3'b000};
        sgn = ~f3[2];
        if (f3[1:0] == 2'b00)
            return {{24{sh[7] & sgn}}, sh[7:0]};
        else if (f3[1:0] == 2'b01)
            return {{16{sh[15] & sgn}}, sh[15:0]};
        else
            return sh;
    endfunction

    // Next-state, field latching and writeback capture
    always_comb begin
        state_d     = state_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        gpr_we_d    = gpr_we_q;
        rd_d        = rd_q;
        csr_wen_d   = csr_wen_q;
        csr_wdata_d = csr_wdata_q;
        pc_d        = pc_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_pend_d   = aw_pend_q;
        w_pend_d    = w_pend_q;
        wb_bus_d    = wb_bus_q;
        wb_pc_d     = wb_pc_q;
        wb_err_d    = wb_err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    f3_d        = in_f3;
                    addr_d      = in_result;
                    gpr_we_d    = in_gpr_we;
                    rd_d        = in_rd;
                    csr_wen_d   = in_csr_wen;
                    csr_wdata_d = in_csr_wdata;
                    pc_d        = in_pc;
                    wdata_d     = in_sdata << {in_result[1:0], 3'b000};
                    wstrb_d     = in_mask << in_result[1:0];
                    aw_pend_d   = 1'b1;
                    w_pend_d    = 1'b1;
                    if (!in_is_mem || in_misal) begin
                        // Retire immediately; a misaligned access never reaches the bus
                        state_d  = S_DONE;
                        wb_bus_d = pack_wb(in_rd, in_csr_wen, in_gpr_we & ~in_misal,
                                           in_csr_wdata, in_result);
                        wb_pc_d  = in_pc;
                        wb_err_d = in_misal;
                    end else if (in_ren) begin
                        state_d = S_AR;
                    end else begin
                        state_d = S_W;
                    end
                end
            end
            S_AR: begin
                if (m_arready) state_d = S_R;
            end
            S_R: begin
                if (m_rvalid) begin
                    state_d  = S_DONE;
                    wb_bus_d = pack_wb(rd_q, csr_wen_q, gpr_we_q, csr_wdata_q,
                                       load_extract(f3_q, addr_q[1:0], m_rdata));
                    wb_pc_d  = pc_q;
                    wb_err_d = (m_rresp != 2'b00);
                end
            end
            S_W: begin
                aw_pend_d = aw_pend_q & ~m_awready;
                w_pend_d  = w_pend_q & ~m_wready;
                if (!aw_pend_d && !w_pend_d) state_d = S_B;
            end
            S_B: begin
                if (m_bvalid) begin
                    state_d  = S_DONE;
                    wb_bus_d = pack_wb(rd_q, csr_wen_q, 1'b0, csr_wdata_q, addr_q);
                    wb_pc_d  = pc_q;
                    wb_err_d = (m_bresp != 2'b00);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            f3_q        <= '0;
            addr_q      <= '0;
            gpr_we_q    <= 1'b0;
            rd_q        <= '0;
            csr_wen_q   <= '0;
            csr_wdata_q <= '0;
            pc_q        <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_pend_q   <= 1'b0;
            w_pend_q    <= 1'b0;
            wb_bus_q    <= '0;
            wb_pc_q     <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            gpr_we_q    <= gpr_we_d;
            rd_q        <= rd_d;
            csr_wen_q   <= csr_wen_d;
            csr_wdata_q <= csr_wdata_d;
            pc_q        <= pc_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_pend_q   <= aw_pend_d;
            w_pend_q    <= w_pend_d;
            wb_bus_q    <= wb_bus_d;
            wb_pc_q     <= wb_pc_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign wb_valid  = (state_q == S_DONE);
    assign wb_bus    = wb_bus_q;
    assign wb_pc     = wb_pc_q;
    assign wb_err    = wb_err_q;
    assign m_addr    = addr_q;
    assign m_arvalid = (state_q == S_AR);
    assign m_rready  = (state_q == S_R);
    assign m_awvalid = (state_q == S_W) & aw_pend_q;
    assign m_wvalid  = (state_q == S_W) & w_pend_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_bready  = (state_q == S_B);

endmodule
